// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master round-robin arbiter/sequencer for the shared
// 16-bit address / 8-bit data memory bus. ROM lives on page ROM_PAGE, RAM on
// every other page. One single-byte transaction at a time: IDLE -> ACCESS -> RESP.
//
// Ports
//   clk, reset                 clock (rising edge), async active-low reset
//   m0_*/m1_* req,we,addr,wdata  master request inputs (held until ack/err)
//   m0_*/m1_* rdata,ack,err      per-master response (one-cycle pulse)
//   mem_addr, mem_wdata        registered bus address / write data
//   mem_we, mem_re             RAM strobes, high for the whole RAM ACCESS state
//   rom_rdata                  combinational ROM read data
//   ram_rdata, ram_ready       RAM read data and completion
//   busy                       high whenever not IDLE
//   owner                      current or last granted master
module mem_bus_arbiter #(
  parameter logic [7:0]  ROM_PAGE = 8'h00,
  parameter int unsigned RAM_WAIT = 1,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  output logic [7:0]  m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic [7:0]  m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  rom_rdata,
  input  logic [7:0]  ram_rdata,
  input  logic        ram_ready,
  output logic        busy,
  output logic        owner
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_last_owner, w_last_owner_nxt;
  logic                r_owner, w_owner_nxt;
  logic                r_we, w_we_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic                r_mem_re, w_mem_re_nxt;
  logic                r_m0_ack, r_m0_err, r_m1_ack, r_m1_err;
  logic [DATA_W-1:0]   r_m0_rdata, r_m1_rdata;
  logic                r_busy;
  logic                w_grant;
  logic                w_done;
  logic                w_fail;
  logic [DATA_W-1:0]   w_data;

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_last_owner <= 1'b1;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
      r_m0_ack     <= 1'b0;
      r_m0_err     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_m1_err     <= 1'b0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_owner      <= w_owner_nxt;
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_cnt        <= w_cnt_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_re     <= w_mem_re_nxt;
      r_m0_ack     <= w_done & ~r_owner;
      r_m0_err     <= w_fail & ~r_owner;
      r_m1_ack     <= w_done & r_owner;
      r_m1_err     <= w_fail & r_owner;
      r_m0_rdata   <= r_owner ? '0 : w_data;
      r_m1_rdata   <= r_owner ? w_data : '0;
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  // Next-state, grant and completion logic
  always_comb begin
    w_state_nxt      = r_state;
    w_last_owner_nxt = r_last_owner;
    w_owner_nxt      = r_owner;
    w_we_nxt         = r_we;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_cnt_nxt        = r_cnt;
    w_mem_we_nxt     = 1'b0;
    w_mem_re_nxt     = 1'b0;
    w_grant          = 1'b0;
    w_done           = 1'b0;
    w_fail           = 1'b0;
    w_data           = '0;

    case (r_state)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the master that did not win last time gets the bus
          w_grant     = (m0_req && m1_req) ? ~r_last_owner : m1_req;
          w_owner_nxt = w_grant;
          w_we_nxt    = w_grant ? m1_we    : m0_we;
          w_addr_nxt  = w_grant ? m1_addr  : m0_addr;
          w_wdata_nxt = w_grant ? m1_wdata : m0_wdata;
          w_cnt_nxt   = '0;
          w_state_nxt = S_ACCESS;
          // Only RAM accesses drive a strobe
          if (w_addr_nxt[15:8] != ROM_PAGE) begin
            w_mem_we_nxt = w_we_nxt;
            w_mem_re_nxt = ~w_we_nxt;
          end
        end
      end

      S_ACCESS: begin
        if (r_addr[15:8] == ROM_PAGE) begin
          w_state_nxt = S_RESP;
          if (r_we) begin
            w_fail = 1'b1;
          end else begin
            w_done = 1'b1;
            w_data = rom_rdata;
          end
        end else if ((r_cnt >= CNT_W'(RAM_WAIT)) && ram_ready) begin
          w_state_nxt = S_RESP;
          w_done      = 1'b1;
          w_data      = r_we ? '0 : ram_rdata;
        end else if (r_cnt >= CNT_W'(TIMEOUT - 1)) begin
          w_state_nxt = S_RESP;
          w_fail      = 1'b1;
        end else begin
          w_cnt_nxt    = r_cnt + CNT_W'(1);
          w_mem_we_nxt = r_mem_we;
          w_mem_re_nxt = r_mem_re;
        end
      end

      S_RESP: begin
        w_state_nxt      = S_IDLE;
        w_last_owner_nxt = r_owner;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;
  assign m0_ack    = r_m0_ack;
  assign m0_err    = r_m0_err;
  assign m0_rdata  = r_m0_rdata;
  assign m1_ack    = r_m1_ack;
  assign m1_err    = r_m1_err;
  assign m1_rdata  = r_m1_rdata;
  assign busy      = r_busy;
  assign owner     = r_owner;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios plus randomized single-master
// transactions, checked against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam logic [7:0] ROM_PAGE = 8'h00;
  localparam int         RAM_WAIT = 1;
  localparam int         TIMEOUT  = 15;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m1_addr;
  logic [7:0]  m0_wdata, m1_wdata;
  logic [7:0]  m0_rdata, m1_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re;
  logic [7:0]  rom_rdata, ram_rdata;
  logic        ram_ready;
  logic        busy, owner;

  int n_tests;
  int n_fail;
  int ready_delay;
  int sc;
  logic ref_last;

  logic [7:0] dev_ram [0:65535];
  logic [7:0] ref_ram [0:65535];

  mem_bus_arbiter #(.ROM_PAGE(ROM_PAGE), .RAM_WAIT(RAM_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .rom_rdata(rom_rdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [15:0] a);
    return a[7:0] ^ 8'hB9;
  endfunction

  // Memory models: ROM is a fixed function, RAM becomes ready ready_delay
  // cycles into a strobe
  assign rom_rdata = rom_f(mem_addr);
  assign ram_rdata = dev_ram[mem_addr];
  assign ram_ready = (sc >= ready_delay);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sc <= 0;
    else if (mem_re || mem_we) sc <= sc + 1;
    else sc <= 0;
  end

  always @(posedge clk) begin
    if (mem_we && ram_ready) dev_ram[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int m, input logic req, input logic we,
                       input logic [15:0] a, input logic [7:0] wd);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = a; m0_wdata = wd;
    end else begin
      m1_req = req; m1_we = we; m1_addr = a; m1_wdata = wd;
    end
  endtask

  // One single-master transaction, compared with the reference outcome
  task automatic run_txn(input int m, input logic we, input logic [15:0] a,
                         input logic [7:0] wd, input int d);
    int   k, exp_access, exp_re, exp_we, n, re_cnt, we_cnt, bad;
    logic rom, exp_err, done;
    logic [7:0] exp_rd;
    logic a_m, e_m, a_o, e_o;
    logic [7:0] rd_m, rd_o;

    rom = (a[15:8] == ROM_PAGE);
    exp_re = 0;
    exp_we = 0;
    if (rom) begin
      exp_access = 1;
      exp_err    = we;
      exp_rd     = rom_f(a);
    end else begin
      k = (d > RAM_WAIT) ? d : RAM_WAIT;
      if (k > TIMEOUT - 1) begin
        exp_access = TIMEOUT;
        exp_err    = 1'b1;
        exp_rd     = 8'h00;
      end else begin
        exp_access = k + 1;
        exp_err    = 1'b0;
        exp_rd     = ref_ram[a];
      end
      if (we) exp_we = exp_access;
      else    exp_re = exp_access;
    end

    ready_delay = d;
    drive(m, 1'b1, we, a, wd);
    n = 0; re_cnt = 0; we_cnt = 0; bad = 0; done = 1'b0;
    while (!done && n < 300) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      // Inputs changing after the grant must not matter
      if (n == 1) drive(m, 1'b1, 1'($urandom), 16'($urandom), 8'($urandom));
      if (mem_re && mem_we) bad++;
      if (mem_re) re_cnt++;
      if (mem_we) we_cnt++;
      if ((mem_re || mem_we) && (mem_addr !== a)) bad++;
      if (mem_we && (mem_wdata !== wd)) bad++;
      if (m0_ack || m0_err || m1_ack || m1_err) done = 1'b1;
    end

    a_m  = (m == 0) ? m0_ack   : m1_ack;
    e_m  = (m == 0) ? m0_err   : m1_err;
    rd_m = (m == 0) ? m0_rdata : m1_rdata;
    a_o  = (m == 0) ? m1_ack   : m0_ack;
    e_o  = (m == 0) ? m1_err   : m0_err;
    rd_o = (m == 0) ? m1_rdata : m0_rdata;

    check("latency", 32'(n), 32'(exp_access + 1));
    check("ack", 32'(a_m), 32'(!exp_err));
    check("err", 32'(e_m), 32'(exp_err));
    if (!we) check("rdata", 32'(rd_m), 32'(exp_rd));
    check("other_master", {22'd0, a_o, e_o, rd_o}, 32'd0);
    check("re_cycles", 32'(re_cnt), 32'(exp_re));
    check("we_cycles", 32'(we_cnt), 32'(exp_we));
    check("bus_values", 32'(bad), 32'd0);
    check("owner", 32'(owner), 32'(m));
    check("busy_resp", 32'(busy), 32'd1);

    if (we && !rom && !exp_err) ref_ram[a] = wd;
    ref_last = 1'(m);
    drive(m, 1'b0, 1'b0, 16'h0000, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("single_pulse", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    logic exp_g;
    logic [15:0] ra;
    n_tests = 0;
    n_fail  = 0;
    ready_delay = 0;
    ref_last = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      dev_ram[i] = 8'(i * 7);
      ref_ram[i] = 8'(i * 7);
    end
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
    check("rst_resp", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);
    check("rst_bus", {8'd0, mem_addr, mem_wdata}, 32'd0);
    check("rst_rdata", {16'd0, m0_rdata, m1_rdata}, 32'd0);

    // Directed scenarios
    run_txn(0, 1'b0, 16'h0010, 8'h00, 0);
    check("rom_value", 32'(rom_f(16'h0010)), 32'h0000_00A9);
    run_txn(1, 1'b1, 16'h2000, 8'h55, 0);
    run_txn(0, 1'b1, 16'h0005, 8'h77, 0);
    run_txn(0, 1'b0, 16'h4000, 8'h00, 999);
    run_txn(1, 1'b0, 16'h2000, 8'h00, 0);

    // Reset in the third RAM wait cycle
    ready_delay = 999;
    drive(0, 1'b1, 1'b0, 16'h4000, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_reset_re", 32'(mem_re), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_re_drop", {30'd0, mem_re, mem_we}, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_owner", 32'(owner), 32'd0);
    drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    ref_last = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_no_resp", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);

    // Both masters requesting: grants must alternate, m0 first after reset
    ready_delay = 0;
    drive(0, 1'b1, 1'b0, 16'h3000, 8'h00);
    drive(1, 1'b1, 1'b0, 16'h0020, 8'h00);
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (!(m0_ack || m0_err || m1_ack || m1_err) && n < 60) begin
        @(posedge clk);
        @(negedge clk);
        n++;
      end
      exp_g = ~ref_last;
      check("alt_bound", 32'(n < 60), 32'd1);
      check("alt_grant", {30'd0, m1_ack, m0_ack}, exp_g ? 32'd2 : 32'd1);
      ref_last = exp_g;
      if (exp_g) m1_req = 1'b0; else m0_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (exp_g) m1_req = 1'b1; else m0_req = 1'b1;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (6) @(negedge clk);
    check("alt_drain", 32'(busy), 32'd0);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) ra = {ROM_PAGE, 8'($urandom)};
      else ra = {8'h10 + 8'($urandom_range(0, 1)), 6'd0, 2'($urandom_range(0, 3))};
      run_txn(int'($urandom_range(0, 1)), 1'($urandom), ra, 8'($urandom),
              ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
